// File: rtl/mult_arbiter.sv
// Round-robin arbiter/sequencer sharing one multi-cycle multiplier among N requesters.
// Define MULT_ARB_TIMEOUT_EN to add a WAIT-state watchdog with a sticky err_o.
module mult_arbiter #(
  parameter int N       = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = 64
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [N-1:0]   req_i,
  input  logic [N*W-1:0] a_i,
  input  logic [N*W-1:0] b_i,
  output logic [N-1:0]   grant_o,
  output logic [N-1:0]   done_o,
  output logic [2*W-1:0] y_o,
  output logic           busy_o,
  output logic           mult_start_o,
  output logic [W-1:0]   mult_a_o,
  output logic [W-1:0]   mult_b_o,
  input  logic           mult_busy_i,
  input  logic [2*W-1:0] mult_y_i,
  output logic           err_o
);

  localparam int IW = $clog2(N);

  if (N < 2 || N > 8 || TIMEOUT < 1) begin : g_bad_params
    $error("mult_arbiter: unsupported parameter values");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_SETTLE = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] ptr;
  logic [IW-1:0] cur;
  logic [IW-1:0] pick;
  logic [N-1:0]  cur_oh;
  logic [W-1:0]  sel_a;
  logic [W-1:0]  sel_b;
  logic          any_req;
  logic          tmo;

  // First requester strictly after the last one served, searching cyclically.
  function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] req, input logic [IW-1:0] last);
    logic [IW-1:0] sel;
    logic [IW-1:0] id;
    logic          hit;
    int            idx;
    sel = last;
    hit = 1'b0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(last) + i) % N;
      id  = idx[IW-1:0];
      if (!hit && req[id]) begin
        sel = id;
        hit = 1'b1;
      end
    end
    return sel;
  endfunction

  assign any_req = |req_i;
  assign pick    = rr_pick(req_i, ptr);
  assign cur_oh  = N'(1) << cur;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < N; k++) begin
      if (pick == IW'(k)) begin
        sel_a = a_i[k*W +: W];
        sel_b = b_i[k*W +: W];
      end
    end
  end

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;

  assign tmo = (state == S_WAIT) && mult_busy_i && (cnt == CW'(TIMEOUT - 1));

  // Counts WAIT cycles; err_o stays set until the next reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt   <= '0;
      err_o <= 1'b0;
    end else begin
      cnt <= (state == S_WAIT) ? cnt + CW'(1) : '0;
      if (tmo) err_o <= 1'b1;
    end
  end
`else
  assign tmo   = 1'b0;
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (any_req) state_nxt = S_LAUNCH;
      S_LAUNCH: state_nxt = S_SETTLE;
      S_SETTLE: state_nxt = S_WAIT;
      S_WAIT:   if (!mult_busy_i || tmo) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Operands are captured on the grant edge only; later a_i/b_i changes are ignored.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ptr      <= IW'(N - 1);
      cur      <= '0;
      mult_a_o <= '0;
      mult_b_o <= '0;
      y_o      <= '0;
    end else begin
      if (state == S_IDLE && any_req) begin
        ptr      <= pick;
        cur      <= pick;
        mult_a_o <= sel_a;
        mult_b_o <= sel_b;
      end
      if (state == S_WAIT) begin
        if (!mult_busy_i) y_o <= mult_y_i;
        else if (tmo)     y_o <= '1;
      end
    end
  end

  always_comb begin
    grant_o      = '0;
    done_o       = '0;
    mult_start_o = 1'b0;
    busy_o       = 1'b0;
    unique case (state)
      S_IDLE: ;
      S_LAUNCH: begin
        grant_o      = cur_oh;
        mult_start_o = 1'b1;
        busy_o       = 1'b1;
      end
      S_SETTLE: busy_o = 1'b1;
      S_WAIT:   busy_o = 1'b1;
      S_DONE: begin
        done_o = cur_oh;
        busy_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter with a behavioural multiplier and round-robin reference model.
module tb_mult_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req = '0;
  logic [N*W-1:0]   a = '0;
  logic [N*W-1:0]   b = '0;
  logic [N-1:0]     grant;
  logic [N-1:0]     done;
  logic [2*W-1:0]   y;
  logic             busy;
  logic             mstart;
  logic [W-1:0]     ma;
  logic [W-1:0]     mb;
  logic             mbusy = 1'b0;
  logic [2*W-1:0]   my = '0;
  logic             err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          k;
    logic [15:0] y;
  } exp_t;
  exp_t q[$];

  int         mptr = N - 1;
  logic [7:0] ea[N];
  logic [7:0] eb[N];
  bit         force_busy = 1'b0;
  bit         scramble = 1'b1;
  int         mlat_fix = 0;
  int         mcnt = 0;
  logic [7:0] la = '0;
  logic [7:0] lb = '0;

  mult_arbiter #(.N(N), .W(W), .TIMEOUT(64)) dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .req_i        (req),
    .a_i          (a),
    .b_i          (b),
    .grant_o      (grant),
    .done_o       (done),
    .y_o          (y),
    .busy_o       (busy),
    .mult_start_o (mstart),
    .mult_a_o     (ma),
    .mult_b_o     (mb),
    .mult_busy_i  (mbusy),
    .mult_y_i     (my),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  // Behavioural shared multiplier: busy for a random number of cycles after start.
  always @(posedge clk) begin
    if (mstart) begin
      la    <= ma;
      lb    <= mb;
      mbusy <= 1'b1;
      my    <= 16'($urandom);
      mcnt  <= (mlat_fix > 0) ? mlat_fix : int'($urandom_range(1, 6));
    end else if (mbusy && !force_busy) begin
      if (mcnt <= 1) begin
        mbusy <= 1'b0;
        my    <= 16'(la) * 16'(lb);
      end else begin
        mcnt <= mcnt - 1;
      end
    end
  end

  // Monitor: every done pulse is checked against the next expected completion.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done !== '0) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done got done=%b y=%0d, none expected", done, y);
      end else begin
        e = q.pop_front();
        if (done !== (4'b0001 << e.k) || y !== e.y) begin
          errors++;
          $display("FAIL done_result got done=%b y=%0d, want done=%b y=%0d",
                   done, y, 4'b0001 << e.k, e.y);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int k, input logic [15:0] yv);
    exp_t e;
    e.k = k;
    e.y = yv;
    q.push_back(e);
    mptr = k;
  endtask

  function automatic logic [7:0] rand_op();
    int r;
    r = $urandom_range(0, 9);
    if (r < 2) return 8'd0;
    if (r < 4) return 8'd255;
    return 8'($urandom);
  endfunction

  function automatic logic [15:0] product(input int k);
    return 16'(ea[k]) * 16'(eb[k]);
  endfunction

  // Every requester in mask posts at once and drops its request on its own done.
  // Service order: ascending cyclic distance from the last requester served.
  task automatic run_batch(input logic [N-1:0] mask, input bit rnd, input int wd);
    logic [N-1:0] pend;
    int           budget;
    bit           wd_on;
    bit           wd_used;
    bit           wd_granted;
    int           base;
    base = mptr;
    for (int i = 0; i < N; i++) begin
      if (rnd && mask[i]) begin
        ea[i] = rand_op();
        eb[i] = rand_op();
      end
    end
    for (int off = 1; off <= N; off++) begin
      if (mask[(base + off) % N]) push_exp((base + off) % N, product((base + off) % N));
    end
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        a[i*W +: W] = ea[i];
        b[i*W +: W] = eb[i];
      end
    end
    req        = req | mask;
    pend       = mask;
    budget     = 0;
    wd_on      = 1'b0;
    wd_used    = 1'b0;
    wd_granted = 1'b0;
    while (pend != '0 && budget < 400) begin
      tick();
      budget++;
      if (wd_on) begin
        req[wd] = 1'b0;
        wd_on   = 1'b0;
      end
      if (wd >= 0 && grant[wd]) wd_granted = 1'b1;
      if (grant != '0) begin
        if (wd >= 0 && !wd_used) begin
          req[wd] = 1'b1;
          wd_on   = 1'b1;
          wd_used = 1'b1;
        end
        for (int i = 0; i < N; i++) begin
          if (scramble && grant[i]) begin
            a[i*W +: W] = 8'd1;
            b[i*W +: W] = 8'($urandom);
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        if (done[i] && pend[i]) begin
          pend[i] = 1'b0;
          req[i]  = 1'b0;
        end
      end
    end
    if (pend != '0) begin
      checks++;
      errors++;
      $display("FAIL batch_timeout got pending=%b want pending=0000", pend);
      req = '0;
      q.delete();
    end
    tick();
    chk("idle_busy_low", 64'(busy), 64'd0);
    chk("queue_drained", 64'(q.size()), 64'd0);
    if (wd >= 0) chk("withdrawn_not_granted", 64'(wd_granted), 64'd0);
  endtask

  // All requesters in mask hold their request for nserv completions.
  task automatic run_held(input logic [N-1:0] mask, input int nserv);
    int cnt;
    int budget;
    int k;
    for (int s = 0; s < nserv; s++) begin
      k = mptr;
      for (int off = 1; off <= N; off++) begin
        if (mask[(mptr + off) % N]) begin
          k = (mptr + off) % N;
          break;
        end
      end
      push_exp(k, product(k));
    end
    for (int i = 0; i < N; i++) begin
      a[i*W +: W] = ea[i];
      b[i*W +: W] = eb[i];
    end
    req    = mask;
    cnt    = 0;
    budget = 0;
    while (cnt < nserv && budget < 600) begin
      tick();
      budget++;
      if (done != '0) cnt++;
    end
    req = '0;
    chk("held_services", 64'(cnt), 64'(nserv));
    tick();
    chk("held_queue_drained", 64'(q.size()), 64'd0);
  endtask

  initial begin
    int budget;
    int t_grant;
    int w;
    logic [N-1:0] m;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 64'({grant, done, y, busy, mstart, ma, mb, err}), 64'd0);
    rst_n = 1'b1;
    tick();

    // Simultaneous pair straight after reset: requester 0 first, then 2.
    ea[0] = 8'd3;  eb[0] = 8'd5;
    ea[2] = 8'd7;  eb[2] = 8'd9;
    run_batch(4'b0101, 1'b0, -1);

    ea[1] = 8'd12; eb[1] = 8'd13;
    run_batch(4'b0010, 1'b0, -1);

    ea[3] = 8'd255; eb[3] = 8'd255;
    run_batch(4'b1000, 1'b0, -1);
    ea[0] = 8'd0;   eb[0] = 8'd200;
    run_batch(4'b0001, 1'b0, -1);

    // Operands are rewritten to a=1 right after grant; the product must still be 100.
    ea[2] = 8'd10;  eb[2] = 8'd10;
    run_batch(4'b0100, 1'b0, -1);

    run_batch(4'b0011, 1'b1, 3);

    repeat (30) begin
      m = N'($urandom_range(1, 15));
      w = $urandom_range(0, N - 1);
      if (m[w]) w = -1;
      run_batch(m, 1'b1, w);
    end

    // Stuck multiplier.
    force_busy = 1'b1;
    ea[1] = 8'd7; eb[1] = 8'd8;
    a[1*W +: W] = ea[1];
    b[1*W +: W] = eb[1];
`ifdef MULT_ARB_TIMEOUT_EN
    push_exp(1, 16'hFFFF);
    req[1]  = 1'b1;
    budget  = 0;
    t_grant = -1;
    while (!done[1] && budget < 300) begin
      tick();
      budget++;
      if (grant[1] && t_grant < 0) t_grant = budget;
    end
    req[1] = 1'b0;
    chk("timeout_done_seen", 64'(done[1]), 64'd1);
    chk("timeout_latency_ok", 64'((budget - t_grant) >= 64 && (budget - t_grant) <= 68), 64'd1);
    force_busy = 1'b0;
    tick();
    chk("timeout_err_set", 64'(err), 64'd1);
    ea[2] = 8'd6; eb[2] = 8'd9;
    run_batch(4'b0100, 1'b0, -1);
    chk("timeout_err_sticky", 64'(err), 64'd1);
`else
    push_exp(1, product(1));
    req[1] = 1'b1;
    repeat (150) tick();
    chk("no_watchdog_still_waiting", 64'(q.size()), 64'd1);
    chk("no_watchdog_busy", 64'(busy), 64'd1);
    chk("no_watchdog_err_low", 64'(err), 64'd0);
    force_busy = 1'b0;
    budget = 0;
    while (!done[1] && budget < 50) begin
      tick();
      budget++;
    end
    req[1] = 1'b0;
    chk("no_watchdog_completes", 64'(done[1]), 64'd1);
    tick();
`endif

    // Reset in the middle of WAIT: abandoned with no done.
    mlat_fix = 30;
    ea[0] = 8'd5; eb[0] = 8'd6;
    a[0 +: W] = ea[0];
    b[0 +: W] = eb[0];
    req = 4'b0001;
    budget = 0;
    while (!grant[0] && budget < 20) begin
      tick();
      budget++;
    end
    chk("midop_granted", 64'(grant[0]), 64'd1);
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midop_reset_outputs", 64'({grant, done, y, busy, mstart, ma, mb, err}), 64'd0);
    req = '0;
    q.delete();
    tick();
    tick();
    chk("midop_reset_held", 64'({done, busy}), 64'd0);
    rst_n    = 1'b1;
    mlat_fix = 0;
    mptr     = N - 1;
    tick();

    // All four held from a fresh reset: 0,1,2,3,0.
    scramble = 1'b0;
    for (int i = 0; i < N; i++) begin
      ea[i] = 8'(i + 2);
      eb[i] = 8'(i * 11 + 1);
    end
    run_held(4'b1111, 5);
    scramble = 1'b1;

    ea[0] = 8'd9; eb[0] = 8'd11;
    run_batch(4'b0001, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
Round-robin arbiter and sequencer that shares one multi-cycle `multiplier` instance among N requesters.
- Each requester posts an operand pair.
- The arbiter grants one requester at a time, latches its operands and pulses the multiplier start.
- It waits for the multiplier to finish, then returns the 16-bit product with a per-requester done pulse.
- Sits between datapath controllers (polynomial evaluators and similar) and the single shared multiplier.

Parameters:
- N, 4, number of requesters (2..8)
- W, 8, operand width; product width is 2*W
- TIMEOUT, 64, watchdog limit in cycles (used only with MULT_ARB_TIMEOUT_EN)

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous active-low reset
- req_i  in  N  request per requester
- a_i  in  N*W  operand A, requester k at bits [k*W +: W]
- b_i  in  N*W  operand B, same packing
- grant_o  out  N  one-hot, 1-cycle pulse: operands of that requester captured
- done_o  out  N  one-hot, 1-cycle pulse: y_o valid for that requester
- y_o  out  2*W  product of the last completed operation, held until the next done
- busy_o  out  1  high while an operation is granted and not yet done
- mult_start_o  out  1  1-cycle start pulse to multiplier rst_i
- mult_a_o  out  W  to multiplier a_bi
- mult_b_o  out  W  to multiplier b_bi
- mult_busy_i  in  1  from multiplier busy_o
- mult_y_i  in  2*W  from multiplier y_bo
- err_o  out  1  sticky watchdog error (MULT_ARB_TIMEOUT_EN only)

Behaviour:
- Reset (rst_i=0, async): state IDLE.
  - grant_o, done_o, y_o, mult_a_o, mult_b_o, mult_start_o, busy_o, err_o all 0.
  - Round-robin pointer = N-1, so requester 0 has first priority.
- FSM states: IDLE, LAUNCH, SETTLE, WAIT, DONE.
- IDLE:
  - If any req_i is set, pick the first set bit after the pointer, searching cyclically.
  - Same edge: latch a_i/b_i slice into mult_a_o/mult_b_o, pulse grant_o[k], store k, update pointer=k, go to LAUNCH.
  - No request: stay in IDLE.
- LAUNCH: mult_start_o=1 for exactly one cycle, then SETTLE.
- SETTLE: one cycle with start=0; absorbs the multiplier's busy latency. Then WAIT.
- WAIT: stay while mult_busy_i=1; on mult_busy_i=0, capture y_o <= mult_y_i and go to DONE.
- DONE:
  - done_o[k]=1 for one cycle, then IDLE.
  - Arbitration resumes the cycle after DONE, giving a minimum of one idle cycle between operations.
- Latency: grant to done = 4 + multiplier busy cycles.
- busy_o = 1 from the cycle after grant through the DONE cycle.
- Operand timing:
  - Operands are sampled only at grant; the requester may change a_i/b_i or drop req_i after grant_o.
  - Dropping req_i before grant withdraws the request with no side effect.
- Requests arriving during an operation wait.
- A requester holding req_i after done_o is re-arbitrated with lowest priority (fairness). With all N held, service order is 0,1,..,N-1,0.
- Simultaneous requests are resolved purely by pointer order.
- Arithmetic is unsigned; y_o is the full 2*W-bit product, no truncation.
- Reset mid-operation: abandon immediately, no done_o, outputs to reset values. The multiplier is reset separately by its own start.

Optional Feature:
MULT_ARB_TIMEOUT_EN
- Defined:
  - A cycle counter runs in WAIT.
  - If mult_busy_i is still 1 after TIMEOUT cycles: set err_o (sticky until reset), set y_o to all-ones, pulse done_o[k], go to IDLE.
  - Counter clears on leaving WAIT.
- Undefined: no counter; err_o tied 0; WAIT has no exit other than mult_busy_i=0.

Test Plan:
- Single request, N=4: req_i=0010, a=12, b=13 -> grant_o=0010; done_o=0010 with y_o=156; busy_o low afterwards.
- Simultaneous: req_i=0101 held (a0=3, b0=5; a2=7, b2=9) -> done order 0 then 2; y_o=15 then 63. All four held -> order 0,1,2,3,0.
- Width extremes: a=255, b=255 -> y_o=65025; a=0, b=200 -> y_o=0.
- Operand change after grant: change a_i slice to 1 one cycle after grant_o (a=10, b=10) -> y_o=100, not 10.
- Reset mid-op: assert rst_i low during WAIT -> all outputs 0 asynchronously, no done_o. Release, then req_i=0001 -> requester 0 served normally.
- With MULT_ARB_TIMEOUT_EN, TIMEOUT=64: mult_busy_i forced 1 -> after 64 WAIT cycles, err_o=1, done_o pulses, y_o=0xFFFF. Next request is still served.
